// File: rtl/instr_sequencer_pkg.sv
// Shared state codes, opcode map and opcode classification helpers for the sequencer.
package instr_sequencer_pkg;

  typedef enum logic [3:0] {
    STATE_HLT    = 4'h0,
    STATE_FETCH0 = 4'h1,
    STATE_FETCH1 = 4'h2,
    STATE_EXEC   = 4'h3
  } state_t;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_END    = 8'h01;
  localparam logic [7:0] OP_ADD    = 8'h10;
  localparam logic [7:0] OP_SUB    = 8'h11;
  localparam logic [7:0] OP_AND    = 8'h12;
  localparam logic [7:0] OP_OR     = 8'h13;
  localparam logic [7:0] OP_XOR    = 8'h14;
  localparam logic [7:0] OP_LIMM16 = 8'h20;
  localparam logic [7:0] OP_LIMM32 = 8'h21;
  localparam logic [7:0] OP_LBSET  = 8'h22;
  localparam logic [7:0] OP_LD     = 8'h30;
  localparam logic [7:0] OP_ST     = 8'h31;

  // Opcodes followed by a second instruction word.
  function automatic logic op_is_2word(input logic [7:0] op);
    return (op == OP_LIMM32) || (op == OP_LBSET);
  endfunction

  function automatic logic op_is_legal(input logic [7:0] op);
    logic legal;
    case (op)
      OP_NOP, OP_END, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_LIMM16, OP_LIMM32, OP_LBSET, OP_LD, OP_ST: legal = 1'b1;
      default:                                      legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: owns the PC, fetches one or two words per
// instruction over a req/ack handshake and dwells one cycle in EXEC.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] start_pc,
  input  logic                step_mode,
  input  logic                stop_req,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [3:0]          current_state,
  output logic [31:0]         instr0,
  output logic [31:0]         instr1,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted,
  output logic                illegal,
  output logic [31:0]         instr_count
);

  state_t     state;
  state_t     state_next;
  logic [7:0] fetch_op;
  logic [7:0] exec_op;

  assign fetch_op      = imem_rdata[31:24];
  assign exec_op       = instr0[31:24];
  assign imem_addr     = pc;
  assign current_state = state;

  // State register; async reset drops imem_req at once since it decodes state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= STATE_HLT;
    else       state <= state_next;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    halted     = 1'b0;
    unique case (state)
      STATE_HLT: begin
        halted = 1'b1;
        if (start) state_next = STATE_FETCH0;
      end
      STATE_FETCH0: begin
        imem_req = 1'b1;
        if (imem_ack) state_next = op_is_2word(fetch_op) ? STATE_FETCH1 : STATE_EXEC;
      end
      STATE_FETCH1: begin
        imem_req = 1'b1;
        if (imem_ack) state_next = STATE_EXEC;
      end
      STATE_EXEC: begin
        if ((exec_op == OP_END) || !op_is_legal(exec_op) || stop_req || step_mode)
          state_next = STATE_HLT;
        else
          state_next = STATE_FETCH0;
      end
      default: state_next = STATE_HLT;
    endcase
  end

  // PC, instruction words, illegal flag and retired counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= '0;
      instr0      <= '0;
      instr1      <= '0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      unique case (state)
        STATE_HLT: begin
          if (start) begin
            pc      <= start_pc;
            illegal <= 1'b0;
          end
        end
        STATE_FETCH0: begin
          if (imem_ack) begin
            instr0 <= imem_rdata;
            instr1 <= '0;
            pc     <= pc + PC_WIDTH'(1);
          end
        end
        STATE_FETCH1: begin
          if (imem_ack) begin
            instr1 <= imem_rdata;
            pc     <= pc + PC_WIDTH'(1);
          end
        end
        STATE_EXEC: begin
          if (instr_count != '1) instr_count <= instr_count + 32'd1;
          if (!op_is_legal(exec_op)) illegal <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a behavioural instruction memory.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] start_pc;
  logic        step_mode;
  logic        stop_req;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [3:0]  current_state;
  logic [31:0] instr0;
  logic [31:0] instr1;
  logic [15:0] pc;
  logic        halted;
  logic        illegal;
  logic [31:0] instr_count;

  logic [31:0] mem [0:65535];
  logic        ack_force;
  int unsigned ack_delay;
  int unsigned wait_cnt;
  int          n_checks = 0;
  int          n_errors = 0;

  instr_sequencer #(.PC_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .step_mode(step_mode), .stop_req(stop_req), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .current_state(current_state), .instr0(instr0), .instr1(instr1), .pc(pc),
    .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Memory answers after ack_delay waiting cycles; ack_force ties ack high.
  assign imem_ack   = ack_force | (imem_req && (wait_cnt >= ack_delay));
  assign imem_rdata = imem_req ? mem[imem_addr] : 32'hFFFF_FFFF;

  always @(posedge clk or posedge reset) begin
    if (reset)                     wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                           wait_cnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] addr);
    start_pc = addr;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic chk_state(input string tag, input state_t exp);
    check(tag, 32'(current_state), 32'(exp));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    mem[16'h0010] = {OP_LIMM16, 24'h001234};
    mem[16'h0011] = {OP_END,    24'h000000};
    mem[16'h0020] = {OP_LIMM32, 24'h000001};
    mem[16'h0021] = 32'hDEADBEEF;
    mem[16'h0030] = {OP_ADD, 24'h000000};
    mem[16'h0031] = {OP_ADD, 24'h000001};
    mem[16'h0032] = {OP_ADD, 24'h000002};
    mem[16'h0033] = {OP_LIMM32, 24'h000003};
    mem[16'h0034] = 32'h12345678;
    mem[16'h0050] = 32'hFF000000;
    mem[16'h0051] = {OP_END, 24'h000000};
    mem[16'hFFFF] = {OP_LBSET, 24'h000000};
    mem[16'h0000] = 32'h00200008;

    reset = 1'b1; start = 1'b0; start_pc = '0; step_mode = 1'b0; stop_req = 1'b0;
    ack_force = 1'b0; ack_delay = 100;
    tick(); tick();
    chk_state("rst_state", STATE_HLT);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_halted", 32'(halted), 32'h1);
    check("rst_illegal", 32'(illegal), 32'h0);
    check("rst_count", instr_count, 32'h0);
    check("rst_instr0", instr0, 32'h0);
    reset = 1'b0;
    tick();

    // Reset in the middle of a stalled FETCH0
    do_start(16'h0040);
    chk_state("t1_fetch0", STATE_FETCH0);
    check("t1_req_hi", 32'(imem_req), 32'h1);
    check("t1_addr", 32'(imem_addr), 32'h0040);
    #2 reset = 1'b1;
    #1;
    check("t1_req_drop", 32'(imem_req), 32'h0);
    chk_state("t1_state", STATE_HLT);
    check("t1_pc", 32'(pc), 32'h0);
    #1 reset = 1'b0;
    tick();

    // Zero-wait run: LIMM16 then END; ack high while halted is ignored
    ack_force = 1'b1;
    tick();
    chk_state("t2_idle_ack", STATE_HLT);
    check("t2_idle_pc", 32'(pc), 32'h0);
    do_start(16'h0010);
    chk_state("t2_c1", STATE_FETCH0);
    check("t2_pc_start", 32'(pc), 32'h0010);
    tick();
    chk_state("t2_c2_exec", STATE_EXEC);
    check("t2_instr0_a", instr0, {OP_LIMM16, 24'h001234});
    tick();
    chk_state("t2_c3", STATE_FETCH0);
    tick();
    chk_state("t2_c4_exec", STATE_EXEC);
    check("t2_instr0_b", instr0, {OP_END, 24'h000000});
    tick();
    chk_state("t2_halt", STATE_HLT);
    check("t2_halted", 32'(halted), 32'h1);
    check("t2_pc", 32'(pc), 32'h0012);
    check("t2_count", instr_count, 32'd2);

    // Two-word instruction with three wait cycles per word
    ack_force = 1'b0; ack_delay = 3; step_mode = 1'b1;
    do_start(16'h0020);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state("t3_wait0", STATE_FETCH0);
      check("t3_req0", 32'(imem_req), 32'h1);
    end
    tick();
    chk_state("t3_fetch1", STATE_FETCH1);
    check("t3_pc1", 32'(pc), 32'h0021);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state("t3_wait1", STATE_FETCH1);
      check("t3_req1", 32'(imem_req), 32'h1);
    end
    tick();
    chk_state("t3_exec", STATE_EXEC);
    check("t3_instr0", instr0, {OP_LIMM32, 24'h000001});
    check("t3_instr1", instr1, 32'hDEADBEEF);
    tick();
    chk_state("t3_halt", STATE_HLT);
    check("t3_instr1_kept", instr1, 32'hDEADBEEF);
    check("t3_pc", 32'(pc), 32'h0022);
    check("t3_count", instr_count, 32'd3);

    // Two-word instruction straddling the PC wrap
    ack_force = 1'b1;
    do_start(16'hFFFF);
    check("t4_pc_start", 32'(pc), 32'hFFFF);
    tick();
    chk_state("t4_fetch1", STATE_FETCH1);
    check("t4_pc_wrap", 32'(pc), 32'h0000);
    tick();
    chk_state("t4_exec", STATE_EXEC);
    check("t4_instr1", instr1, 32'h00200008);
    tick();
    chk_state("t4_halt", STATE_HLT);
    check("t4_pc", 32'(pc), 32'h0001);

    // Single-step through three ADDs, resuming at the returned pc
    for (int i = 0; i < 3; i++) begin
      do_start(16'h0030 + 16'(i));
      chk_state("t5_fetch", STATE_FETCH0);
      tick();
      chk_state("t5_exec", STATE_EXEC);
      check("t5_instr0", instr0, {OP_ADD, 24'(i)});
      tick();
      chk_state("t5_halt", STATE_HLT);
      check("t5_pc", 32'(pc), 32'h0031 + 32'(i));
    end
    // stop_req raised during FETCH1 only takes effect after EXEC
    step_mode = 1'b0;
    do_start(16'h0033);
    tick();
    chk_state("t5_f1", STATE_FETCH1);
    stop_req = 1'b1;
    tick();
    chk_state("t5_stop_exec", STATE_EXEC);
    check("t5_stop_instr1", instr1, 32'h12345678);
    tick();
    chk_state("t5_stop_halt", STATE_HLT);
    check("t5_stop_pc", 32'(pc), 32'h0035);
    // start and stop together: start wins, stop halts after the first EXEC
    do_start(16'h0030);
    chk_state("t5_start_wins", STATE_FETCH0);
    tick();
    chk_state("t5_sw_exec", STATE_EXEC);
    tick();
    chk_state("t5_sw_halt", STATE_HLT);
    check("t5_sw_pc", 32'(pc), 32'h0031);
    check("t5_count", instr_count, 32'd9);
    stop_req = 1'b0;

    // Undefined opcode halts and sets illegal; next start clears it
    do_start(16'h0050);
    tick();
    chk_state("t6_exec", STATE_EXEC);
    check("t6_ill_pre", 32'(illegal), 32'h0);
    tick();
    chk_state("t6_halt", STATE_HLT);
    check("t6_illegal", 32'(illegal), 32'h1);
    check("t6_halted", 32'(halted), 32'h1);
    check("t6_pc", 32'(pc), 32'h0051);
    check("t6_count", instr_count, 32'd10);
    do_start(16'h0051);
    check("t6_ill_clr", 32'(illegal), 32'h0);
    chk_state("t6_restart", STATE_FETCH0);
    tick();
    tick();
    chk_state("t6_end_halt", STATE_HLT);
    check("t6_ill_end", 32'(illegal), 32'h0);
    check("t6_count_end", instr_count, 32'd11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
